// File: rtl/keypad_scan_fifo.sv
// Keypad matrix scanner with per-key debounce feeding a key-code FIFO; codes appear one cycle after push.
// Consumer pops with key_ack; presses arriving while the FIFO is full are dropped and flagged sticky.

module sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr_vld,
  input  logic [W-1:0] wr_dat,
  output logic         wr_rdy,
  output logic         rd_vld,
  output logic [W-1:0] rd_dat,
  input  logic         rd_rdy
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic [W-1:0] mem [DEPTH];
  logic         full;
  logic         empty;
  logic         do_wr;
  logic         do_rd;

  // Extra pointer MSB separates full (MSBs differ) from empty (pointers equal).
  assign empty  = (wr_ptr == rd_ptr);
  assign full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_vld = !empty;
  assign do_rd  = rd_rdy && !empty;
  assign wr_rdy = !full || do_rd;
  assign do_wr  = wr_vld && wr_rdy;
  assign rd_dat = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_rd) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_dat;
  end
endmodule

module keypad_scan_fifo #(
  parameter int N_FILAS    = 4,
  parameter int N_COLUMNAS = 4,
  parameter int SCAN_DIV   = 50000,
  parameter int DEBOUNCE   = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int KEY_W      = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_COLUMNAS-1:0] columna,
  output logic [N_FILAS-1:0]    fila,
  output logic [KEY_W-1:0]      key,
  output logic                  keypad_pressed,
  input  logic                  key_ack,
  output logic                  held,
  output logic                  overflow
);
  localparam int RW = (N_FILAS > 1) ? $clog2(N_FILAS) : 1;
  localparam int DW = $clog2(SCAN_DIV);
  localparam int CW = $clog2(DEBOUNCE + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE);

  logic [N_COLUMNAS-1:0]          col_meta;
  logic [N_COLUMNAS-1:0]          col_sync;
  logic [DW-1:0]                  dwell;
  logic [RW-1:0]                  row_idx;
  logic                           sample;

  logic [N_COLUMNAS-1:0][CW-1:0]  cnt [N_FILAS];
  logic [N_COLUMNAS-1:0]          deb [N_FILAS];
  logic [N_COLUMNAS-1:0][CW-1:0]  cnt_nxt;
  logic [N_COLUMNAS-1:0]          deb_nxt;
  logic [N_COLUMNAS-1:0]          press_ev;
  logic [N_COLUMNAS-1:0]          win_oh;
  logic                           win_found;
  int                             win_col;

  logic                           push_vld;
  logic                           push_rdy;
  logic [KEY_W-1:0]               push_code;
  logic                           pop_vld;
  logic [KEY_W-1:0]               head;

  assign sample = (dwell == DW'(SCAN_DIV - 1));
  assign fila   = ~(N_FILAS'(1) << row_idx);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_meta <= '1;
      col_sync <= '1;
      dwell    <= '0;
      row_idx  <= '0;
    end else begin
      col_meta <= columna;
      col_sync <= col_meta;
      if (sample) begin
        dwell   <= '0;
        row_idx <= (row_idx == RW'(N_FILAS - 1)) ? '0 : row_idx + RW'(1);
      end else begin
        dwell <= dwell + DW'(1);
      end
    end
  end

  // Only the lowest-column event is accepted; other ready keys stay armed for a later frame.
  always_comb begin
    cnt_nxt   = '0;
    deb_nxt   = '0;
    press_ev  = '0;
    win_oh    = '0;
    win_found = 1'b0;
    win_col   = 0;
    for (int c = 0; c < N_COLUMNAS; c++) begin
      if (!col_sync[c]) begin
        cnt_nxt[c]  = (cnt[row_idx][c] == CNT_MAX) ? CNT_MAX : cnt[row_idx][c] + CW'(1);
        press_ev[c] = (cnt_nxt[c] == CNT_MAX) && !deb[row_idx][c];
      end
    end
    for (int c = 0; c < N_COLUMNAS; c++) begin
      if (press_ev[c] && !win_found) begin
        win_found = 1'b1;
        win_col   = c;
        win_oh[c] = 1'b1;
      end
    end
    for (int c = 0; c < N_COLUMNAS; c++) begin
      deb_nxt[c] = !col_sync[c] && (deb[row_idx][c] || win_oh[c]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < N_FILAS; r++) begin
        cnt[r] <= '0;
        deb[r] <= '0;
      end
    end else if (sample) begin
      cnt[row_idx] <= cnt_nxt;
      deb[row_idx] <= deb_nxt;
    end
  end

  always_comb begin
    held = 1'b0;
    for (int r = 0; r < N_FILAS; r++) begin
      held = held | (|deb[r]);
    end
  end

  assign push_vld  = sample && win_found;
  assign push_code = KEY_W'(int'(row_idx) * N_COLUMNAS + win_col);

  sync_fifo #(
    .W     (KEY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .wr_vld (push_vld),
    .wr_dat (push_code),
    .wr_rdy (push_rdy),
    .rd_vld (pop_vld),
    .rd_dat (head),
    .rd_rdy (key_ack)
  );

  // A dropped code keeps its key debounced, so it is never retried while held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) overflow <= 1'b0;
    else if (push_vld && !push_rdy) overflow <= 1'b1;
  end

  assign keypad_pressed = pop_vld;
  assign key            = pop_vld ? head : '0;
endmodule

// File: tb/tb_keypad_scan_fifo.sv
// Directed bench for keypad_scan_fifo with a 4x4 matrix model driven from fila.
module tb_keypad_scan_fifo;
  logic             clk = 1'b0;
  logic             rst;
  logic [3:0]       columna;
  logic [3:0]       fila;
  logic [4:0]       key;
  logic             keypad_pressed;
  logic             key_ack;
  logic             held;
  logic             overflow;
  logic [3:0][3:0]  keys;
  int               cyc;
  int               checks;
  int               failures;
  logic [3:0]       exp_fila;
  int               exp_q [3];

  keypad_scan_fifo #(
    .N_FILAS    (4),
    .N_COLUMNAS (4),
    .SCAN_DIV   (4),
    .DEBOUNCE   (2),
    .FIFO_DEPTH (4),
    .KEY_W      (5)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .columna        (columna),
    .fila           (fila),
    .key            (key),
    .keypad_pressed (keypad_pressed),
    .key_ack        (key_ack),
    .held           (held),
    .overflow       (overflow)
  );

  always #5 clk = ~clk;

  always_comb begin
    columna = '1;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!fila[r] && keys[r][c]) columna[c] = 1'b0;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic tick_to(input int target);
    while (cyc < target) tick();
  endtask

  task automatic reset_on();
    rst = 1'b1;
    #1;
  endtask

  task automatic reset_off();
    @(negedge clk);
    rst = 1'b0;
    cyc = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    checks = 0; failures = 0; cyc = 0;
    rst = 1'b0; key_ack = 1'b0; keys = '0;
    exp_q[0] = 11; exp_q[1] = 12; exp_q[2] = 5;
    #1;

    // Reset state, then free-running row scan with key 9 held.
    keys[2][1] = 1'b1;
    reset_on();
    check_eq("rst_fila", fila, 4'b1110);
    check_eq("rst_key", key, 0);
    check_eq("rst_kp", keypad_pressed, 0);
    check_eq("rst_held", held, 0);
    check_eq("rst_ovf", overflow, 0);
    reset_off();
    for (int i = 0; i < 20; i++) begin
      tick();
      exp_fila = ~(4'b0001 << ((cyc / 4) % 4));
      check_eq("fila_step", fila, exp_fila);
    end

    // Held key 9: pushed at second row-2 sample, exactly once.
    tick_to(27);
    check_eq("k9_kp_early", keypad_pressed, 0);
    check_eq("k9_held_early", held, 0);
    tick_to(28);
    check_eq("k9_kp", keypad_pressed, 1);
    check_eq("k9_key", key, 9);
    check_eq("k9_held", held, 1);
    tick_to(60);
    check_eq("k9_still", key, 9);
    key_ack = 1'b1; tick(); key_ack = 1'b0;
    check_eq("k9_pop_kp", keypad_pressed, 0);
    check_eq("k9_pop_key", key, 0);
    check_eq("k9_pop_held", held, 1);
    keys[2][1] = 1'b0;
    tick_to(75);
    check_eq("k9_rel_held_pre", held, 1);
    tick_to(76);
    check_eq("k9_rel_held", held, 0);
    check_eq("k9_rel_kp", keypad_pressed, 0);

    // Bounce on key 2: pressed only on alternate row-0 samples.
    reset_on(); keys = '0; keys[0][2] = 1'b1; reset_off();
    tick_to(10); keys[0][2] = 1'b0;
    tick_to(26); keys[0][2] = 1'b1;
    tick_to(42); keys[0][2] = 1'b0;
    tick_to(58); keys[0][2] = 1'b1;
    tick_to(70);
    check_eq("bounce_kp_mid", keypad_pressed, 0);
    tick_to(74); keys[0][2] = 1'b0;
    tick_to(90);
    check_eq("bounce_kp", keypad_pressed, 0);
    check_eq("bounce_held", held, 0);

    // Same-row simultaneous presses: code 4 first, code 7 one frame later.
    reset_on(); keys = '0; keys[1][0] = 1'b1; keys[1][3] = 1'b1; reset_off();
    tick_to(23);
    check_eq("dual_kp_early", keypad_pressed, 0);
    tick_to(24);
    check_eq("dual_first", key, 4);
    check_eq("dual_held", held, 1);
    tick_to(30);
    key_ack = 1'b1; tick(); key_ack = 1'b0;
    check_eq("dual_gap_kp", keypad_pressed, 0);
    tick_to(39);
    check_eq("dual_kp_pre7", keypad_pressed, 0);
    tick_to(40);
    check_eq("dual_second", key, 7);
    key_ack = 1'b1; tick(); key_ack = 1'b0;
    check_eq("dual_empty", keypad_pressed, 0);
    check_eq("dual_ovf", overflow, 0);

    // Overflow: codes 1,6,11,12 fill the FIFO, code 3 is dropped.
    reset_on();
    keys = '0;
    keys[0][1] = 1'b1; keys[0][3] = 1'b1; keys[1][2] = 1'b1; keys[2][3] = 1'b1; keys[3][0] = 1'b1;
    reset_off();
    tick_to(32);
    check_eq("ovf_head", key, 1);
    check_eq("ovf_pre32", overflow, 0);
    tick_to(35);
    check_eq("ovf_pre36", overflow, 0);
    tick_to(36);
    check_eq("ovf_set", overflow, 1);
    check_eq("ovf_head_kept", key, 1);
    keys[1][1] = 1'b1;
    tick_to(55);
    key_ack = 1'b1; tick(); key_ack = 1'b0;
    check_eq("ovf_pushpop_head", key, 6);
    check_eq("ovf_pushpop_kp", keypad_pressed, 1);
    for (int i = 0; i < 3; i++) begin
      key_ack = 1'b1; tick(); key_ack = 1'b0;
      check_eq("ovf_order", key, exp_q[i]);
    end
    key_ack = 1'b1; tick(); key_ack = 1'b0;
    check_eq("ovf_drained", keypad_pressed, 0);
    check_eq("ovf_sticky", overflow, 1);
    check_eq("ovf_held", held, 1);

    // Reset mid-dwell of row 3 clears everything immediately.
    tick_to(62);
    check_eq("mid_fila_pre", fila, 4'b0111);
    reset_on();
    check_eq("mid_fila", fila, 4'b1110);
    check_eq("mid_held", held, 0);
    check_eq("mid_ovf", overflow, 0);
    check_eq("mid_kp", keypad_pressed, 0);
    reset_off();

    // Keys still held re-queue after reset; a second reset discards the queue.
    tick_to(20);
    check_eq("requeue_head", key, 1);
    tick_to(24);
    check_eq("requeue_kp", keypad_pressed, 1);
    reset_on();
    check_eq("discard_kp", keypad_pressed, 0);
    check_eq("discard_key", key, 0);
    keys = '0;
    reset_off();

    // key_ack while empty is ignored; push with ack on empty still lands.
    key_ack = 1'b1;
    tick_to(20);
    check_eq("ackempty_kp", keypad_pressed, 0);
    check_eq("ackempty_ovf", overflow, 0);
    tick_to(40);
    keys[3][2] = 1'b1;
    tick_to(63);
    check_eq("ackempty_kp_pre", keypad_pressed, 0);
    tick_to(64);
    key_ack = 1'b0;
    check_eq("ackempty_push_kp", keypad_pressed, 1);
    check_eq("ackempty_push_key", key, 14);
    tick();
    check_eq("ackempty_hold_key", key, 14);
    check_eq("ackempty_ovf_end", overflow, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
